multi_lift_hall_call_tracker: RTL and testbench

//  Return path of the multi-lift hall-call crossbar. Latches hall-button presses into pending up/dn requests.

---
 rtl/lift_pkg.sv | 24 ++
 rtl/lift_nearest_select.sv | 35 +++
 rtl/multi_lift_hall_call_tracker.sv | 166 ++++++++++++++++
 tb/tb_multi_lift_hall_call_tracker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared sizes, slot type and scan states for the hall-call tracker
package lift_pkg;

    localparam int N_FLOORS = 12;
    localparam int N_LIFTS  = 10;
    localparam int TMO_W    = 8;
    localparam int FLOOR_W  = $clog2(N_FLOORS);
    localparam int LIFT_W   = $clog2(N_LIFTS);
    localparam int N_SLOTS  = 2 * N_FLOORS;
    localparam int SLOT_W   = $clog2(N_SLOTS);

    // Slots 0..N_FLOORS-1 are up calls, N_FLOORS..N_SLOTS-1 are down calls
    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        S_SCAN   = 1'b0,
        S_ASSIGN = 1'b1
    } scan_state_t;

    function automatic slot_t next_slot(input slot_t s);
        return (s == slot_t'(N_SLOTS - 1)) ? '0 : s + slot_t'(1);
    endfunction

endpackage

// File: rtl/lift_nearest_select.sv
// rtl/lift_nearest_select.sv - picks the nearest available lift to a target floor, lowest index on ties
module lift_nearest_select
    import lift_pkg::*;
(
    input  logic [N_LIFTS-1:0]         i_avail,
    input  logic [N_LIFTS*FLOOR_W-1:0] i_floors,
    input  logic [FLOOR_W-1:0]         i_target,
    output logic                       o_valid,
    output logic [LIFT_W-1:0]          o_winner
);

    logic [FLOOR_W-1:0] w_best_dist;
    logic [FLOOR_W-1:0] w_floor;
    logic [FLOOR_W-1:0] w_dist;

    // Linear sweep; strict less-than keeps the earlier (lower-index) lift on equal distance
    always_comb begin
        o_valid     = 1'b0;
        o_winner    = '0;
        w_best_dist = '0;
        w_floor     = '0;
        w_dist      = '0;
        for (int i = 0; i < N_LIFTS; i++) begin
            w_floor = i_floors[i*FLOOR_W +: FLOOR_W];
            w_dist  = (w_floor >= i_target) ? (w_floor - i_target) : (i_target - w_floor);
            if (i_avail[i] && (w_floor < FLOOR_W'(N_FLOORS)) &&
                (!o_valid || (w_dist < w_best_dist))) begin
                o_valid     = 1'b1;
                o_winner    = LIFT_W'(i);
                w_best_dist = w_dist;
            end
        end
    end

endmodule

// File: rtl/multi_lift_hall_call_tracker.sv
// rtl/multi_lift_hall_call_tracker.sv - hall-call latches, lift assignment scan and route masks; HALL_CALL_TIMEOUT_EN adds reassignment timers
module multi_lift_hall_call_tracker
    import lift_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_FLOORS-1:0]          up_btn,
    input  logic [N_FLOORS-1:0]          dn_btn,
    input  logic [N_LIFTS*FLOOR_W-1:0]   lift_floor,
    input  logic [N_LIFTS-1:0]           lift_idle,
    input  logic [N_LIFTS-1:0]           lift_door_open,
    input  logic [N_LIFTS-1:0]           lift_dir_up,
    output logic [N_FLOORS-1:0]          up_rqst,
    output logic [N_FLOORS-1:0]          dn_rqst,
    output logic [N_LIFTS*N_FLOORS-1:0]  up_route,
    output logic [N_LIFTS*N_FLOORS-1:0]  dn_route
);

    localparam int ROUTE_IDX_W = $clog2(N_LIFTS * N_FLOORS);
    // No up button on the top floor, no down button on the bottom floor
    localparam logic [N_FLOORS-1:0] UP_BTN_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_BTN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    logic [N_FLOORS-1:0]         r_up_rqst;
    logic [N_FLOORS-1:0]         r_dn_rqst;
    logic [N_LIFTS*N_FLOORS-1:0] r_up_route;
    logic [N_LIFTS*N_FLOORS-1:0] r_dn_route;
    scan_state_t                 r_state;
    slot_t                       r_ptr;
    logic [LIFT_W-1:0]           r_winner;

    logic [N_FLOORS-1:0]         w_up_clr;
    logic [N_FLOORS-1:0]         w_dn_clr;
    logic [N_FLOORS-1:0]         w_up_asg;
    logic [N_FLOORS-1:0]         w_dn_asg;
    logic [N_FLOORS-1:0]         w_up_tmo;
    logic [N_FLOORS-1:0]         w_dn_tmo;
    logic [N_LIFTS-1:0]          w_busy;
    logic [N_LIFTS-1:0]          w_avail;
    logic                        w_slot_is_up;
    logic [FLOOR_W-1:0]          w_tgt_floor;
    logic                        w_slot_pending;
    logic                        w_slot_asg;
    logic                        w_slot_clr;
    logic                        w_sel_valid;
    logic [LIFT_W-1:0]           w_sel_winner;
    logic [ROUTE_IDX_W-1:0]      w_route_idx;

    // Door-open reports become per-floor clear strobes; route bits are summarised per floor and per lift
    always_comb begin
        w_up_clr = '0;
        w_dn_clr = '0;
        w_up_asg = '0;
        w_dn_asg = '0;
        w_busy   = '0;
        for (int i = 0; i < N_LIFTS; i++) begin
            for (int f = 0; f < N_FLOORS; f++) begin
                if (lift_door_open[i] && (lift_floor[i*FLOOR_W +: FLOOR_W] == FLOOR_W'(f))) begin
                    if (lift_dir_up[i]) w_up_clr[f] = 1'b1;
                    else                w_dn_clr[f] = 1'b1;
                end
                w_up_asg[f] = w_up_asg[f] | r_up_route[i*N_FLOORS+f];
                w_dn_asg[f] = w_dn_asg[f] | r_dn_route[i*N_FLOORS+f];
                w_busy[i]   = w_busy[i] | r_up_route[i*N_FLOORS+f] | r_dn_route[i*N_FLOORS+f];
            end
        end
    end

    // A lift holding any route is kept out of the pool so it carries one assignment at a time
    assign w_avail        = lift_idle & ~w_busy;
    assign w_slot_is_up   = (r_ptr < slot_t'(N_FLOORS));
    assign w_tgt_floor    = w_slot_is_up ? FLOOR_W'(r_ptr) : FLOOR_W'(r_ptr - slot_t'(N_FLOORS));
    assign w_slot_pending = w_slot_is_up ? r_up_rqst[w_tgt_floor] : r_dn_rqst[w_tgt_floor];
    assign w_slot_asg     = w_slot_is_up ? w_up_asg[w_tgt_floor]  : w_dn_asg[w_tgt_floor];
    assign w_slot_clr     = w_slot_is_up ? w_up_clr[w_tgt_floor]  : w_dn_clr[w_tgt_floor];
    assign w_route_idx    = ROUTE_IDX_W'(r_winner) * ROUTE_IDX_W'(N_FLOORS) + ROUTE_IDX_W'(w_tgt_floor);

    lift_nearest_select u_select (
        .i_avail  (w_avail),
        .i_floors (lift_floor),
        .i_target (w_tgt_floor),
        .o_valid  (w_sel_valid),
        .o_winner (w_sel_winner)
    );

    // Hall-call latches: set on a press, cleared by a matching door-open (clear dominates)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_up_rqst <= '0;
            r_dn_rqst <= '0;
        end else begin
            r_up_rqst <= (r_up_rqst | (up_btn & UP_BTN_MASK)) & ~w_up_clr;
            r_dn_rqst <= (r_dn_rqst | (dn_btn & DN_BTN_MASK)) & ~w_dn_clr;
        end
    end

    // Scan FSM owns the route masks: drops on clear/timeout, sets only from S_ASSIGN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_SCAN;
            r_ptr      <= '0;
            r_winner   <= '0;
            r_up_route <= '0;
            r_dn_route <= '0;
        end else begin
            r_up_route <= r_up_route & ~{N_LIFTS{w_up_clr | w_up_tmo}};
            r_dn_route <= r_dn_route & ~{N_LIFTS{w_dn_clr | w_dn_tmo}};
            case (r_state)
                S_SCAN: begin
                    if (w_slot_pending && !w_slot_asg && w_sel_valid) begin
                        r_winner <= w_sel_winner;
                        r_state  <= S_ASSIGN;
                    end else begin
                        r_ptr <= next_slot(r_ptr);
                    end
                end
                S_ASSIGN: begin
                    if (w_slot_pending && !w_slot_clr) begin
                        if (w_slot_is_up) r_up_route[w_route_idx] <= 1'b1;
                        else              r_dn_route[w_route_idx] <= 1'b1;
                    end
                    r_ptr   <= next_slot(r_ptr);
                    r_state <= S_SCAN;
                end
                default: r_state <= S_SCAN;
            endcase
        end
    end

`ifdef HALL_CALL_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo [N_SLOTS];

    // Per-slot age of the current assignment; saturation releases the lift while the call stays pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SLOTS; s++) r_tmo[s] <= '0;
        end else begin
            for (int f = 0; f < N_FLOORS; f++) begin
                if (!w_up_asg[f] || w_up_clr[f] || (r_tmo[f] == '1)) r_tmo[f] <= '0;
                else r_tmo[f] <= r_tmo[f] + TMO_W'(1);
                if (!w_dn_asg[f] || w_dn_clr[f] || (r_tmo[N_FLOORS+f] == '1)) r_tmo[N_FLOORS+f] <= '0;
                else r_tmo[N_FLOORS+f] <= r_tmo[N_FLOORS+f] + TMO_W'(1);
            end
        end
    end

    // Expiry strobe per slot
    always_comb begin
        w_up_tmo = '0;
        w_dn_tmo = '0;
        for (int f = 0; f < N_FLOORS; f++) begin
            w_up_tmo[f] = w_up_asg[f] && (r_tmo[f] == '1);
            w_dn_tmo[f] = w_dn_asg[f] && (r_tmo[N_FLOORS+f] == '1);
        end
    end
`else
    assign w_up_tmo = '0;
    assign w_dn_tmo = '0;
`endif

    assign up_rqst  = r_up_rqst;
    assign dn_rqst  = r_dn_rqst;
    assign up_route = r_up_route;
    assign dn_route = r_dn_route;

endmodule

// File: tb/tb_multi_lift_hall_call_tracker.sv
// tb/tb_multi_lift_hall_call_tracker.sv - self-checking bench for multi_lift_hall_call_tracker
module tb_multi_lift_hall_call_tracker;

    localparam int NF = 12;
    localparam int NL = 10;
    localparam int FW = 4;
    localparam int NS = 2 * NF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NF-1:0]   up_btn;
    logic [NF-1:0]   dn_btn;
    logic [NL*FW-1:0] lift_floor;
    logic [NL-1:0]   lift_idle;
    logic [NL-1:0]   lift_door_open;
    logic [NL-1:0]   lift_dir_up;
    logic [NF-1:0]   up_rqst;
    logic [NF-1:0]   dn_rqst;
    logic [NL*NF-1:0] up_route;
    logic [NL*NF-1:0] dn_route;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_lift_hall_call_tracker dut (
        .clk            (clk),
        .rst            (rst),
        .up_btn         (up_btn),
        .dn_btn         (dn_btn),
        .lift_floor     (lift_floor),
        .lift_idle      (lift_idle),
        .lift_door_open (lift_door_open),
        .lift_dir_up    (lift_dir_up),
        .up_rqst        (up_rqst),
        .dn_rqst        (dn_rqst),
        .up_route       (up_route),
        .dn_route       (dn_route)
    );

    // Reference model: pending flags, owning lift per call slot (-1 = none), scan position
    bit m_up [NF];
    bit m_dn [NF];
    int m_owner [NS];
    int m_ptr;
    bit m_assigning;
    int m_win;

    function automatic int floor_of(input int i);
        return int'(lift_floor[i*FW +: FW]);
    endfunction

    function automatic int pick_nearest(input int f);
        int best = -1;
        int bd = 0;
        for (int i = 0; i < NL; i++) begin
            bit busy = 1'b0;
            int d;
            for (int s = 0; s < NS; s++) if (m_owner[s] == i) busy = 1'b1;
            d = (floor_of(i) > f) ? floor_of(i) - f : f - floor_of(i);
            if (lift_idle[i] && !busy && floor_of(i) < NF && (best < 0 || d < bd)) begin
                best = i;
                bd = d;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin m_up[f] = 1'b0; m_dn[f] = 1'b0; end
        for (int s = 0; s < NS; s++) m_owner[s] = -1;
        m_ptr = 0;
        m_assigning = 1'b0;
        m_win = 0;
    endtask

    task automatic model_step();
        bit cu [NF];
        bit cd [NF];
        int f;
        int w;
        bit is_up;
        bit pend;
        bit clr;
        for (int k = 0; k < NF; k++) begin cu[k] = 1'b0; cd[k] = 1'b0; end
        for (int i = 0; i < NL; i++)
            if (lift_door_open[i] && floor_of(i) < NF) begin
                if (lift_dir_up[i]) cu[floor_of(i)] = 1'b1;
                else                cd[floor_of(i)] = 1'b1;
            end
        is_up = (m_ptr < NF);
        f     = m_ptr % NF;
        pend  = is_up ? m_up[f] : m_dn[f];
        clr   = is_up ? cu[f] : cd[f];
        if (m_assigning) begin
            if (pend && !clr) m_owner[m_ptr] = m_win;
            m_ptr = (m_ptr + 1) % NS;
            m_assigning = 1'b0;
        end else begin
            w = pick_nearest(f);
            if (pend && m_owner[m_ptr] < 0 && w >= 0) begin
                m_win = w;
                m_assigning = 1'b1;
            end else begin
                m_ptr = (m_ptr + 1) % NS;
            end
        end
        for (int k = 0; k < NF; k++) begin
            if (cu[k]) m_owner[k] = -1;
            if (cd[k]) m_owner[NF+k] = -1;
            m_up[k] = (m_up[k] || (up_btn[k] && k != NF-1)) && !cu[k];
            m_dn[k] = (m_dn[k] || (dn_btn[k] && k != 0)) && !cd[k];
        end
    endtask

    function automatic logic [127:0] exp_rqst(input bit up);
        logic [127:0] v = '0;
        for (int k = 0; k < NF; k++) v[k] = up ? m_up[k] : m_dn[k];
        return v;
    endfunction

    function automatic logic [127:0] exp_route(input bit up);
        logic [127:0] v = '0;
        for (int k = 0; k < NF; k++) begin
            int o = up ? m_owner[k] : m_owner[NF+k];
            if (o >= 0) v[o*NF+k] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("cmp_up_rqst",  up_rqst,  exp_rqst(1'b1));
        check("cmp_dn_rqst",  dn_rqst,  exp_rqst(1'b0));
        check("cmp_up_route", up_route, exp_route(1'b1));
        check("cmp_dn_route", dn_route, exp_route(1'b0));
    end

    task automatic set_lift(input int i, input bit idle, input int fl);
        lift_idle[i] = idle;
        lift_floor[i*FW +: FW] = 4'(fl);
    endtask

    task automatic wait_route(input bit up, input int idx, input int budget, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            seen = up ? up_route[idx] : dn_route[idx];
        end
        check(name, up ? up_route[idx] : dn_route[idx], 1);
    endtask

    function automatic logic [NF-1:0] route_row(input bit up, input int i);
        return up ? up_route[i*NF +: NF] : dn_route[i*NF +: NF];
    endfunction

    initial begin
        model_reset();
        up_btn = '0; dn_btn = '0; lift_floor = '0;
        lift_idle = '0; lift_door_open = '0; lift_dir_up = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_up_rqst",  up_rqst,  0);
        check("reset_dn_rqst",  dn_rqst,  0);
        check("reset_up_route", up_route, 0);
        check("reset_dn_route", dn_route, 0);

        // Up press served by the only idle lift
        set_lift(2, 1'b1, 5);
        up_btn[3] = 1'b1;
        @(negedge clk);
        up_btn[3] = 1'b0;
        check("t1_up_rqst3", up_rqst[3], 1);
        wait_route(1'b1, 2*NF+3, 25, "t1_up_route_l2_f3");

        // Down call at 3 stays unassigned (lift 2 is holding a route)
        dn_btn[3] = 1'b1;
        @(negedge clk);
        dn_btn[3] = 1'b0;
        check("t3_dn_rqst3_set", dn_rqst[3], 1);

        // Clear up 3 via lift 2 door-open heading up
        set_lift(2, 1'b0, 3);
        lift_door_open[2] = 1'b1; lift_dir_up[2] = 1'b1;
        @(negedge clk);
        lift_door_open[2] = 1'b0;
        check("t3_up_rqst3_clr",  up_rqst[3], 0);
        check("t3_up_route27_clr", up_route[2*NF+3], 0);
        check("t3_dn_rqst3_kept", dn_rqst[3], 1);
        lift_door_open[2] = 1'b1; lift_dir_up[2] = 1'b0;
        @(negedge clk);
        lift_door_open[2] = 1'b0;
        check("t3_dn_rqst3_clr", dn_rqst[3], 0);

        // Tie-break between lifts 1 (floor 4) and 4 (floor 8) for down call at 6
        set_lift(1, 1'b1, 4);
        set_lift(4, 1'b1, 8);
        dn_btn[6] = 1'b1;
        @(negedge clk);
        dn_btn[6] = 1'b0;
        wait_route(1'b0, 1*NF+6, 25, "t2_dn_route_l1_f6");
        check("t2_dn_route_l4_f6", dn_route[4*NF+6], 0);
        check("t2_l4_up_row", route_row(1'b1, 4), 0);
        check("t2_l4_dn_row", route_row(1'b0, 4), 0);

        // Press and clear on the same slot in the same cycle
        set_lift(0, 1'b0, 5);
        lift_door_open[0] = 1'b1; lift_dir_up[0] = 1'b1;
        up_btn[5] = 1'b1;
        @(negedge clk);
        up_btn[5] = 1'b0; lift_door_open[0] = 1'b0;
        check("t4_up_rqst5_collision", up_rqst[5], 0);

        // Edges and no-available-lift
        lift_idle = '0;
        set_lift(1, 1'b0, 6);
        lift_door_open[1] = 1'b1; lift_dir_up[1] = 1'b0;
        @(negedge clk);
        lift_door_open[1] = 1'b0;
        check("t5_dn_rqst6_clr",  dn_rqst[6], 0);
        check("t5_dn_route18_clr", dn_route[1*NF+6], 0);
        up_btn[11] = 1'b1; dn_btn[0] = 1'b1;
        @(negedge clk);
        up_btn[11] = 1'b0; dn_btn[0] = 1'b0;
        check("t5_up_rqst11_ignored", up_rqst[11], 0);
        check("t5_dn_rqst0_ignored",  dn_rqst[0], 0);
        up_btn[8] = 1'b1;
        @(negedge clk);
        up_btn[8] = 1'b0;
        check("t5_up_rqst8_set", up_rqst[8], 1);
        repeat (30) @(negedge clk);
        begin
            logic [NL-1:0] col;
            for (int i = 0; i < NL; i++) col[i] = up_route[i*NF+8];
            check("t5_no_idle_no_route", col, 0);
        end
        set_lift(7, 1'b1, 0);
        wait_route(1'b1, 7*NF+8, 25, "t5_up_route_l7_f8");

        // Asynchronous reset mid-operation
        set_lift(3, 1'b1, 9);
        dn_btn[9] = 1'b1;
        @(negedge clk);
        dn_btn[9] = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_async_up_rqst",  up_rqst,  0);
        check("t6_async_dn_rqst",  dn_rqst,  0);
        check("t6_async_up_route", up_route, 0);
        check("t6_async_dn_route", dn_route, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_post_dn_rqst",  dn_rqst,  0);
        check("t6_post_up_route", up_route, 0);
        check("t6_post_dn_route", dn_route, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
